// File: rtl/sram_pkg.sv
// Shared defaults and FSM state type for the 8K x 8 SRAM responder.
package sram_pkg;
    localparam int SRAM_ADDR_WIDTH = 13;
    localparam int SRAM_DATA_WIDTH = 8;
    localparam int SRAM_WE_WIDTH   = 1;
    localparam int SRAM_CNT_WIDTH  = 16;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;
endpackage

// File: rtl/sram_array_8kx8.sv
// Plain storage: one shared address, one write, one registered read, no reset.
// Kept free of control logic so it can be replaced by a foundry macro.
module sram_array_8kx8 #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  b_clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge b_clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/sram_8kx8_resp.sv
// SRAM responder: init sweep, access control, saturating counters, oen gating.
// Optional stuck-at read fault injection when SRAM_FAULT_INJ_EN is defined.
module sram_8kx8_resp
    import sram_pkg::*;
#(
    parameter int WE_WIDTH   = SRAM_WE_WIDTH,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0,
    parameter int CNT_WIDTH  = SRAM_CNT_WIDTH
) (
    input  logic                          b_clk,
    input  logic                          b_rst_n,
    input  logic                          cen,
    input  logic [WE_WIDTH-1:0]           wen,
    input  logic                          oen,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [DATA_WIDTH-1:0]         data_in,
`ifdef SRAM_FAULT_INJ_EN
    input  logic                          flt_en,
    input  logic [ADDR_WIDTH-1:0]         flt_addr,
    input  logic [$clog2(DATA_WIDTH)-1:0] flt_bit,
    input  logic                          flt_val,
`endif
    output logic [DATA_WIDTH-1:0]         ram_read_out,
    output logic                          init_done,
    output logic [CNT_WIDTH-1:0]          rd_cnt,
    output logic [CNT_WIDTH-1:0]          wr_cnt
);
    sram_state_e           state_reg;
    logic [ADDR_WIDTH-1:0] init_ptr_reg;
    logic [CNT_WIDTH-1:0]  rd_cnt_reg;
    logic [CNT_WIDTH-1:0]  wr_cnt_reg;
    logic                  rd_src_reg;
    logic                  in_init;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rd_data_next;

    assign in_init   = (state_reg == INIT);
    assign rd_acc    = !in_init && !cen && (wen != '0);
    assign wr_acc    = !in_init && !cen && (wen == '0);
    assign mem_we    = in_init || wr_acc;
    // The array only loads on oen=0 reads, so its output register doubles as hold state.
    assign mem_re    = rd_acc && !oen;
    assign mem_addr  = in_init ? init_ptr_reg : addr;
    assign mem_wdata = in_init ? INIT_VAL : data_in;

    sram_array_8kx8 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .b_clk (b_clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            state_reg    <= INIT;
            init_ptr_reg <= '0;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
            rd_src_reg   <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    if (init_ptr_reg == '1)
                        state_reg <= READY;
                    else
                        init_ptr_reg <= init_ptr_reg + 1'b1;
                end
                default: begin
                    if (wr_acc && wr_cnt_reg != '1)
                        wr_cnt_reg <= wr_cnt_reg + 1'b1;
                    if (rd_acc) begin
                        if (rd_cnt_reg != '1)
                            rd_cnt_reg <= rd_cnt_reg + 1'b1;
                        rd_src_reg <= !oen;
                    end
                end
            endcase
        end
    end

`ifdef SRAM_FAULT_INJ_EN
    logic                          flt_hit_reg;
    logic [$clog2(DATA_WIDTH)-1:0] flt_bit_reg;
    logic                          flt_val_reg;

    // Fault applies only to data that actually came from the array (oen=0 reads).
    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            flt_hit_reg <= 1'b0;
            flt_bit_reg <= '0;
            flt_val_reg <= 1'b0;
        end else if (rd_acc) begin
            flt_hit_reg <= flt_en && (addr == flt_addr);
            flt_bit_reg <= flt_bit;
            flt_val_reg <= flt_val;
        end
    end

    always_comb begin
        rd_data_next = mem_rdata;
        if (flt_hit_reg)
            rd_data_next[flt_bit_reg] = flt_val_reg;
    end
`else
    assign rd_data_next = mem_rdata;
`endif

    assign ram_read_out = rd_src_reg ? rd_data_next : '0;
    assign init_done    = !in_init;
    assign rd_cnt       = rd_cnt_reg;
    assign wr_cnt       = wr_cnt_reg;
endmodule

// File: tb/tb_sram_8kx8_resp.sv
// Directed, table-driven bench for sram_8kx8_resp, plus a small-geometry
// instance used to reach counter saturation quickly.
module tb_sram_8kx8_resp;
    logic        b_clk = 1'b0;
    logic        b_rst_n = 1'b0;
    logic        cen = 1'b1;
    logic [0:0]  wen = 1'b1;
    logic        oen = 1'b0;
    logic [12:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  ram_read_out;
    logic        init_done;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    logic        s_cen = 1'b1;
    logic [0:0]  s_wen = 1'b1;
    logic [3:0]  s_addr = '0;
    logic [7:0]  s_out;
    logic        s_init_done;
    logic [3:0]  s_rd_cnt;
    logic [3:0]  s_wr_cnt;

`ifdef SRAM_FAULT_INJ_EN
    logic        flt_en = 1'b0;
    logic [12:0] flt_addr = '0;
    logic [2:0]  flt_bit = '0;
    logic        flt_val = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 b_clk = ~b_clk;

    sram_8kx8_resp dut (
        .b_clk        (b_clk),
        .b_rst_n      (b_rst_n),
        .cen          (cen),
        .wen          (wen),
        .oen          (oen),
        .addr         (addr),
        .data_in      (data_in),
`ifdef SRAM_FAULT_INJ_EN
        .flt_en       (flt_en),
        .flt_addr     (flt_addr),
        .flt_bit      (flt_bit),
        .flt_val      (flt_val),
`endif
        .ram_read_out (ram_read_out),
        .init_done    (init_done),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    sram_8kx8_resp #(.ADDR_WIDTH(4), .CNT_WIDTH(4)) dut_small (
        .b_clk        (b_clk),
        .b_rst_n      (b_rst_n),
        .cen          (s_cen),
        .wen          (s_wen),
        .oen          (1'b0),
        .addr         (s_addr),
        .data_in      (8'h00),
`ifdef SRAM_FAULT_INJ_EN
        .flt_en       (1'b0),
        .flt_addr     (4'h0),
        .flt_bit      (3'd0),
        .flt_val      (1'b0),
`endif
        .ram_read_out (s_out),
        .init_done    (s_init_done),
        .rd_cnt       (s_rd_cnt),
        .wr_cnt       (s_wr_cnt)
    );

    typedef struct {
        string       name;
        logic        cen;
        logic        wen;
        logic        oen;
        logic [12:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_out;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge b_clk);
        #1;
    endtask

    task automatic access(input logic c, input logic w, input logic o,
                          input logic [12:0] a, input logic [7:0] d);
        cen = c; wen = w; oen = o; addr = a; data_in = d;
        step();
    endtask

    task automatic wait_init(input string name, input int exp_cycles);
        int cycles;
        cycles = 0;
        while (!init_done && cycles < 9000) begin
            step();
            cycles++;
        end
        cen = 1'b1;
        check(name, cycles, exp_cycles);
    endtask

    initial begin
        int sweep_bad;
        vecs[0]  = '{"wr A5 @0010",       1'b0, 1'b0, 1'b0, 13'h0010, 8'hA5, 8'h00, 0, 1};
        vecs[1]  = '{"rd @0010",          1'b0, 1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5, 1, 1};
        vecs[2]  = '{"rd @0010 oen=1",    1'b0, 1'b1, 1'b1, 13'h0010, 8'h00, 8'h00, 2, 1};
        vecs[3]  = '{"idle wen=0",        1'b1, 1'b0, 1'b0, 13'h0010, 8'h33, 8'h00, 2, 1};
        vecs[4]  = '{"rd @0010 again",    1'b0, 1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5, 3, 1};
        vecs[5]  = '{"idle read",         1'b1, 1'b1, 1'b0, 13'h0000, 8'h00, 8'hA5, 3, 1};
        vecs[6]  = '{"wr 5A @1FFF",       1'b0, 1'b0, 1'b0, 13'h1FFF, 8'h5A, 8'hA5, 3, 2};
        vecs[7]  = '{"rd @1FFF",          1'b0, 1'b1, 1'b0, 13'h1FFF, 8'h00, 8'h5A, 4, 2};
        vecs[8]  = '{"rd @0000 post-init", 1'b0, 1'b1, 1'b0, 13'h0000, 8'h00, 8'h00, 5, 2};
        vecs[9]  = '{"wr 3C @0000",       1'b0, 1'b0, 1'b0, 13'h0000, 8'h3C, 8'h00, 5, 3};
        vecs[10] = '{"rd @0000",          1'b0, 1'b1, 1'b0, 13'h0000, 8'h00, 8'h3C, 6, 3};
        vecs[11] = '{"wr C3 @0001",       1'b0, 1'b0, 1'b0, 13'h0001, 8'hC3, 8'h3C, 6, 4};
        vecs[12] = '{"rd @0001",          1'b0, 1'b1, 1'b0, 13'h0001, 8'h00, 8'hC3, 7, 4};
        vecs[13] = '{"rd @0010 final",    1'b0, 1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5, 8, 4};

        // Reset state
        repeat (2) @(posedge b_clk);
        #1;
        check("reset ram_read_out", ram_read_out, 0);
        check("reset init_done", init_done, 0);
        check("reset rd_cnt", rd_cnt, 0);
        check("reset wr_cnt", wr_cnt, 0);

        // Attempt a write of FF to 0000 throughout INIT; it must be ignored.
        cen = 1'b0; wen = 1'b0; oen = 1'b0; addr = 13'h0000; data_in = 8'hFF;
        b_rst_n = 1'b1;
        wait_init("init cycles", 8192);
        check("post-init rd_cnt", rd_cnt, 0);
        check("post-init wr_cnt", wr_cnt, 0);
        check("post-init ram_read_out", ram_read_out, 0);

        // Every word reads INIT_VAL
        sweep_bad = 0;
        for (int a = 0; a < 8192; a++) begin
            access(1'b0, 1'b1, 1'b0, 13'(a), 8'h00);
            if (ram_read_out !== 8'h00) begin
                if (sweep_bad < 4)
                    $display("FAIL sweep @%0h: got 0x%0h expected 0x0", a, ram_read_out);
                sweep_bad++;
            end
        end
        checks++;
        if (sweep_bad != 0) errors++;
        check("sweep rd_cnt", rd_cnt, 8192);
        check("sweep wr_cnt", wr_cnt, 0);

        for (int i = 0; i < 14; i++) begin
            access(vecs[i].cen, vecs[i].wen, vecs[i].oen, vecs[i].addr, vecs[i].din);
            check({vecs[i].name, " out"}, ram_read_out, vecs[i].exp_out);
            check({vecs[i].name, " rd_cnt"}, rd_cnt, vecs[i].exp_rd + 8192);
            check({vecs[i].name, " wr_cnt"}, wr_cnt, vecs[i].exp_wr);
        end

        // cen held high for 5 cycles with write-looking controls: nothing moves
        for (int i = 0; i < 5; i++) begin
            access(1'b1, 1'b0, 1'b0, 13'h0010, 8'h77);
            check("cen hold out", ram_read_out, 8'hA5);
            check("cen hold rd_cnt", rd_cnt, 8200);
            check("cen hold wr_cnt", wr_cnt, 4);
        end
        access(1'b0, 1'b1, 1'b0, 13'h0010, 8'h00);
        check("after hold rd @0010", ram_read_out, 8'hA5);

`ifdef SRAM_FAULT_INJ_EN
        access(1'b0, 1'b0, 1'b0, 13'h1FFF, 8'hFF);
        access(1'b0, 1'b0, 1'b0, 13'h1FFE, 8'hFF);
        flt_en = 1'b1; flt_addr = 13'h1FFF; flt_bit = 3'd3; flt_val = 1'b0;
        access(1'b0, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        check("fault rd @1FFF", ram_read_out, 8'hF7);
        access(1'b0, 1'b1, 1'b0, 13'h1FFE, 8'h00);
        check("fault rd @1FFE", ram_read_out, 8'hFF);
        flt_en = 1'b0;
        access(1'b0, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        check("fault off rd @1FFF", ram_read_out, 8'hFF);
        cen = 1'b1;
`endif

        // Reset mid-INIT at pointer 0x0800
        b_rst_n = 1'b0;
        #2;
        check("async reset init_done", init_done, 0);
        check("async reset rd_cnt", rd_cnt, 0);
        check("async reset out", ram_read_out, 0);
        step();
        b_rst_n = 1'b1;
        repeat (2048) step();
        check("mid-init init_done", init_done, 0);
        b_rst_n = 1'b0;
        #2;
        check("mid-init reset init_done", init_done, 0);
        step();
        b_rst_n = 1'b1;
        wait_init("re-init cycles", 8192);
        check("re-init wr_cnt", wr_cnt, 0);

        // Saturation on the narrow-counter instance
        check("small init_done", s_init_done, 1);
        s_cen = 1'b0; s_wen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_addr = 4'(i);
            step();
            if (i == 13) check("small rd_cnt 14", s_rd_cnt, 14);
            if (i == 14) check("small rd_cnt 15", s_rd_cnt, 15);
        end
        check("small rd_cnt saturated", s_rd_cnt, 15);
        s_wen = 1'b0;
        for (int i = 0; i < 18; i++) step();
        s_cen = 1'b1;
        check("small wr_cnt saturated", s_wr_cnt, 15);
        check("small rd_cnt held", s_rd_cnt, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
